// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an asynchronous-read FIFO into bounded bursts on a
// registered valid/ready stream. A burst starts on a fill threshold, an idle
// timeout, or an explicit flush. o_last marks the final beat of each burst.
module fifo_burst_reader #(
  parameter int unsigned BW       = 8,
  parameter int unsigned LGFLEN   = 4,
  parameter int unsigned MAXBURST = 8,
  parameter int unsigned LGTMO    = 8,
  parameter int unsigned TIMEOUT  = 100
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output logic              o_fifo_rd,
  input  logic [BW-1:0]     i_fifo_data,
  input  logic              i_fifo_empty,
  input  logic [LGFLEN:0]   i_fifo_fill,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [BW-1:0]     o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int unsigned     FW       = LGFLEN + 1;
  localparam logic [FW-1:0]   MAX_FILL = FW'(MAXBURST);
  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [LGTMO-1:0] TMO_LAST = LGTMO'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [FW-1:0]    rem;
  logic [LGTMO-1:0] timer;

  logic fill_nz;
  logic tmo_hit;
  logic start_c;
  logic accept_c;

  // Trigger evaluation and handshake decode
  assign fill_nz   = (i_fifo_fill != '0);
  assign tmo_hit   = TMO_EN && (timer == TMO_LAST);
  assign start_c   = fill_nz && ((i_fifo_fill >= MAX_FILL) || tmo_hit || i_flush);
  assign accept_c  = o_valid && i_ready;
  assign o_fifo_rd = (state == BURST) && (rem != '0) && !i_fifo_empty && (!o_valid || accept_c);

  // Burst FSM, idle timer and registered stream outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      rem     <= '0;
      timer   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      if (accept_c) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (o_fifo_rd) begin
        o_data  <= i_fifo_data;
        o_valid <= 1'b1;
        o_last  <= (rem == FW'(1));
        rem     <= rem - FW'(1);
      end
      case (state)
        IDLE: begin
          if (start_c) begin
            state  <= BURST;
            o_busy <= 1'b1;
            rem    <= (i_fifo_fill >= MAX_FILL) ? MAX_FILL : i_fifo_fill;
            timer  <= '0;
          end else if (!fill_nz) begin
            timer <= '0;
          end else if (timer != '1) begin
            timer <= timer + LGTMO'(1);
          end
        end
        BURST: begin
          if (o_fifo_rd && (rem == FW'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept_c && o_last) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
